// File: rtl/mux16_rr_arbiter_pkg.sv
// Shared widths and state encoding for the 16:1 mux round-robin arbiter.
// The mux datapath and the arbiter both size their select logic from N_IN/SEL_W.
package mux16_rr_arbiter_pkg;

   localparam int N_IN   = 16;
   localparam int SEL_W  = 4;
   localparam int HOLD_W = 8;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_e;

endpackage

// File: rtl/mux16_rr_arbiter_rr_pick16.sv
// Circular first-set-bit search over 16 requests, starting at ptr_i.
// Rotating first lets a single fixed lowest-bit encoder serve every pointer value.
module rr_pick16
   import mux16_rr_arbiter_pkg::*;
(
   input  logic [N_IN-1:0]  req_i,
   input  logic [SEL_W-1:0] ptr_i,
   output logic [SEL_W-1:0] idx_o,
   output logic             found_o
);

   logic [2*N_IN-1:0] dbl;
   logic [N_IN-1:0]   rot;
   logic [SEL_W-1:0]  off;

   assign dbl = {req_i, req_i} >> ptr_i;
   assign rot = dbl[N_IN-1:0];

   always_comb begin
      off     = '0;
      found_o = 1'b0;
      for (int i = N_IN - 1; i >= 0; i--) begin
         if (rot[i]) begin
            off     = SEL_W'(i);
            found_o = 1'b1;
         end
      end
   end

   // 4-bit add wraps mod 16, undoing the rotation.
   assign idx_o = off + ptr_i;

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter driving the 16:1 mux select; grants are bounded to MAX_HOLD
// cycles and always followed by one idle cycle. All outputs are registered.
module mux16_rr_arbiter
   import mux16_rr_arbiter_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 8
)(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic [N_IN-1:0]  req_i,
   output logic [N_IN-1:0]  gnt_o,
   output logic [SEL_W-1:0] sel_o,
   output logic             busy_o
);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   arb_state_e        state_q, state_d;
   logic [SEL_W-1:0]  ptr_q, ptr_d;
   logic [SEL_W-1:0]  owner_q, owner_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [N_IN-1:0]   gnt_q, gnt_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic              busy_q, busy_d;

   logic [SEL_W-1:0]  pick_idx;
   logic              pick_found;

   rr_pick16 u_pick (
      .req_i   (req_i),
      .ptr_i   (ptr_q),
      .idx_o   (pick_idx),
      .found_o (pick_found)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      hold_d  = hold_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      busy_d  = busy_q;
      case (state_q)
         ST_IDLE: begin
            gnt_d  = '0;
            busy_d = 1'b0;
            if (en_i && pick_found) begin
               state_d         = ST_GRANT;
               owner_d         = pick_idx;
               sel_d           = pick_idx;
               gnt_d[pick_idx] = 1'b1;
               busy_d          = 1'b1;
               hold_d          = '0;
            end
         end
         ST_GRANT: begin
            // Owner drop and hold limit on the same cycle collapse into one release.
            if (!req_i[owner_q] || (hold_q == HOLD_LAST)) begin
               state_d = ST_IDLE;
               gnt_d   = '0;
               busy_d  = 1'b0;
               ptr_d   = owner_q + SEL_W'(1);
               hold_d  = '0;
            end else begin
               hold_d  = hold_q + HOLD_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         hold_q  <= '0;
         gnt_q   <= '0;
         sel_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         hold_q  <= hold_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         busy_q  <= busy_d;
      end
   end

   assign gnt_o  = gnt_q;
   assign sel_o  = sel_q;
   assign busy_o = busy_q;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Scoreboard bench: a cycle model of the arbitration rules pushes expected outputs
// each edge; a negedge monitor pops and compares two instances (MAX_HOLD 8 and 1).
module tb_mux16_rr_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en  = 1'b0;
   logic [15:0] req = '0;

   logic [15:0] gnt_a, gnt_b;
   logic [3:0]  sel_a, sel_b;
   logic        busy_a, busy_b;

   always #5 clk = ~clk;

   mux16_rr_arbiter #(.MAX_HOLD(8)) u_a (
      .clk_i(clk), .rst_i(rst), .en_i(en), .req_i(req),
      .gnt_o(gnt_a), .sel_o(sel_a), .busy_o(busy_a)
   );

   mux16_rr_arbiter #(.MAX_HOLD(1)) u_b (
      .clk_i(clk), .rst_i(rst), .en_i(en), .req_i(req),
      .gnt_o(gnt_b), .sel_o(sel_b), .busy_o(busy_b)
   );

   typedef struct {
      logic        busy;
      logic [15:0] gnt;
      logic [3:0]  sel;
      int          ptr;
      int          owner;
      int          hold;
   } mstate_t;

   typedef struct packed {
      logic [15:0] gnt;
      logic [3:0]  sel;
      logic        busy;
   } obs_t;

   mstate_t ma = '{1'b0, 16'h0, 4'h0, 0, 0, 0};
   mstate_t mb = '{1'b0, 16'h0, 4'h0, 0, 0, 0};
   obs_t    qa[$];
   obs_t    qb[$];

   int n_cmp = 0;
   int n_err = 0;

   logic fair_chk = 1'b0;
   int   fair_exp = 0;
   int   fair_cnt = 0;
   logic prev_busy_b = 1'b0;

   // One clock edge of the arbiter as described by its rules.
   function automatic mstate_t m_step(mstate_t s, logic r, logic e, logic [15:0] rq, int maxh);
      mstate_t n = s;
      bit      hit = 0;
      if (r) begin
         n.busy = 0; n.gnt = '0; n.sel = '0; n.ptr = 0; n.owner = 0; n.hold = 0;
      end else if (!s.busy) begin
         n.gnt = '0;
         if (e) begin
            for (int k = 0; k < 16; k++) begin
               int j = (s.ptr + k) % 16;
               if (!hit && rq[j]) begin
                  hit = 1;
                  n.busy = 1; n.owner = j; n.sel = 4'(j); n.hold = 0;
                  n.gnt = 16'h0001 << j;
               end
            end
         end
      end else if (!rq[s.owner] || s.hold == maxh - 1) begin
         n.busy = 0; n.gnt = '0; n.hold = 0; n.ptr = (s.owner + 1) % 16;
      end else begin
         n.hold = s.hold + 1;
      end
      return n;
   endfunction

   always @(posedge clk) begin
      ma = m_step(ma, rst, en, req, 8);
      mb = m_step(mb, rst, en, req, 1);
      qa.push_back('{ma.gnt, ma.sel, ma.busy});
      qb.push_back('{mb.gnt, mb.sel, mb.busy});
   end

   always @(negedge clk) begin
      obs_t e;
      if (qa.size() > 0) begin
         e = qa.pop_front();
         n_cmp++;
         if ({gnt_a, sel_a, busy_a} !== e) begin
            n_err++;
            $display("FAIL hold8 t=%0t got gnt=%h sel=%0d busy=%b exp gnt=%h sel=%0d busy=%b",
                     $time, gnt_a, sel_a, busy_a, e.gnt, e.sel, e.busy);
         end
      end
      if (qb.size() > 0) begin
         e = qb.pop_front();
         n_cmp++;
         if ({gnt_b, sel_b, busy_b} !== e) begin
            n_err++;
            $display("FAIL hold1 t=%0t got gnt=%h sel=%0d busy=%b exp gnt=%h sel=%0d busy=%b",
                     $time, gnt_b, sel_b, busy_b, e.gnt, e.sel, e.busy);
         end
      end
      // Fairness: with all requests high, successive winners must count 0..15 and wrap.
      if (fair_chk && busy_b === 1'b1 && prev_busy_b !== 1'b1) begin
         n_cmp++;
         if (sel_b !== 4'(fair_exp)) begin
            n_err++;
            $display("FAIL fair_seq t=%0t got sel=%0d exp sel=%0d", $time, sel_b, fair_exp);
         end
         fair_exp = (fair_exp + 1) % 16;
         fair_cnt++;
      end
      prev_busy_b = busy_b;
   end

   task automatic drive(input logic r, input logic e, input logic [15:0] q, input int n);
      rst = r; en = e; req = q;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_grant_a();
      int w = 0;
      while (busy_a !== 1'b1 && w < 20) begin
         @(posedge clk); #1;
         w++;
      end
      if (w >= 20) begin
         n_cmp++; n_err++;
         $display("FAIL wait_grant got busy=%b exp busy=1 within 20 cycles", busy_a);
      end
   endtask

   initial begin
      drive(1, 0, 16'h0000, 3);
      // single held request: 8-cycle grants separated by one idle cycle
      drive(0, 1, 16'h0008, 20);
      drive(0, 1, 16'h0000, 2);
      // early release
      drive(0, 1, 16'h0100, 4);
      drive(0, 1, 16'h0000, 3);
      // pointer priority: owner 14 leaves ptr at 15
      drive(0, 1, 16'h4000, 1);
      wait_grant_a();
      drive(0, 1, 16'h4000, 2);
      drive(0, 1, 16'h0000, 2);
      drive(0, 1, 16'h8002, 14);
      // enable gating, then en dropped mid-grant
      drive(0, 0, 16'h0001, 10);
      drive(0, 1, 16'h0001, 2);
      drive(0, 0, 16'h0001, 12);
      drive(0, 0, 16'h0000, 3);
      // fairness and wrap
      drive(1, 0, 16'h0000, 2);
      fair_exp = 0;
      fair_chk = 1'b1;
      drive(0, 1, 16'hFFFF, 40);
      fair_chk = 1'b0;
      // reset mid-grant, then re-request
      drive(0, 1, 16'h0000, 2);
      drive(0, 1, 16'h0020, 3);
      drive(1, 1, 16'h0020, 1);
      drive(0, 1, 16'h0020, 4);
      // random traffic
      for (int i = 0; i < 400; i++) begin
         logic        r, e;
         logic [15:0] q;
         r = ($urandom_range(0, 99) < 2);
         e = ($urandom_range(0, 9) != 0);
         case ($urandom_range(0, 3))
            0:       q = 16'h0;
            1:       q = 16'(1 << $urandom_range(0, 15));
            2:       q = 16'($urandom);
            default: q = 16'($urandom & $urandom);
         endcase
         drive(r, e, q, 1);
      end
      drive(0, 0, 16'h0000, 3);
      @(negedge clk); #1;
      n_cmp++;
      if (fair_cnt < 17) begin
         n_err++;
         $display("FAIL fair_count got %0d grants exp at least 17", fair_cnt);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
